// File: rtl/csr_wr_arb_pkg.sv
// csr_wr_arb_pkg: shared constants and types for the CSR write arbiter.
//   CSR_AW / CSR_DW   : CSR address / data widths
//   CSR_MSTATUS/MEPC/MCAUSE : machine CSR addresses written by the trap sequencer
//   arb_state_t       : arbiter FSM state encoding
//   csr_wr_t          : one {addr,data} CSR write, also the buffer entry format
package csr_wr_arb_pkg;
  localparam int CSR_AW = 12;
  localparam int CSR_DW = 32;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUF  = 2'b01,
    S_LOCK = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic [CSR_AW-1:0] addr;
    logic [CSR_DW-1:0] data;
  } csr_wr_t;
endpackage

// File: rtl/csr_wr_arb_if.sv
// csr_wr_arb_if: bundle of all csr_wr_arb data/handshake signals.
//   slave  modport : the arbiter side (takes cl/ex writes and ID read, drives csr write port)
//   master modport : the surrounding pipeline / csr_regs side
interface csr_wr_arb_if;
  import csr_wr_arb_pkg::*;

  logic              cl_csr_we_i;
  logic [CSR_AW-1:0] cl_csr_waddr_i;
  logic [CSR_DW-1:0] cl_csr_wdata_i;
  logic              cl_busy_i;
  logic              ex_csr_we_i;
  logic [CSR_AW-1:0] ex_csr_waddr_i;
  logic [CSR_DW-1:0] ex_csr_wdata_i;
  logic [CSR_AW-1:0] id_csr_raddr_i;
  logic [CSR_DW-1:0] csr_rdata_i;
  logic              csr_we_o;
  logic [CSR_AW-1:0] csr_waddr_o;
  logic [CSR_DW-1:0] csr_wdata_o;
  logic [CSR_DW-1:0] id_csr_rdata_o;
  logic              arb_stall_o;

  modport slave (
    input  cl_csr_we_i, cl_csr_waddr_i, cl_csr_wdata_i, cl_busy_i,
    input  ex_csr_we_i, ex_csr_waddr_i, ex_csr_wdata_i,
    input  id_csr_raddr_i, csr_rdata_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, id_csr_rdata_o, arb_stall_o
  );

  modport master (
    output cl_csr_we_i, cl_csr_waddr_i, cl_csr_wdata_i, cl_busy_i,
    output ex_csr_we_i, ex_csr_waddr_i, ex_csr_wdata_i,
    output id_csr_raddr_i, csr_rdata_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, id_csr_rdata_o, arb_stall_o
  );
endinterface

// File: rtl/csr_wr_fifo.sv
// csr_wr_fifo: DEPTH-entry {addr,data} FIFO for deferred EX CSR writes.
//   clk, rst      : clock, synchronous active-high reset (pointers/count only)
//   push/push_ent : enqueue at tail (ignored when full, judged on pre-pop count)
//   pop           : dequeue head (ignored when empty)
//   head          : entry at the head
//   count/full/empty : occupancy, 0..DEPTH
//   rptr/ents     : read pointer and raw storage, used for read forwarding
module csr_wr_fifo
  import csr_wr_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  csr_wr_t                   push_ent,
  input  logic                      pop,
  output csr_wr_t                   head,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH)-1:0]  rptr,
  output csr_wr_t [DEPTH-1:0]       ents
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]        wptr;
  csr_wr_t [DEPTH-1:0]  mem;
  logic                 do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  // full is taken before the pop, so a slot freed this cycle is not reusable yet
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];
  assign ents    = mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage is not reset; entries are only meaningful below count
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_ent;
  end
endmodule

// File: rtl/csr_wr_arb.sv
// csr_wr_arb: arbitrates the single csr_regs write port between the trap
// sequencer (cl) and CSR instructions in EX, buffering EX writes that lose.
//   clk, rst : clock, synchronous active-high reset
//   bus      : csr_wr_arb_if.slave (cl/ex write requests, ID read address and
//              raw read data in; registered write port, forwarded read data,
//              combinational stall out)
// Priority per cycle: cl write, then buffer head, then EX direct (buffer empty).
// Build option: define CSR_ARB_FWD_EN to forward pending writes to ID reads;
// without it, reads of a pending address stall instead.
module csr_wr_arb
  import csr_wr_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  csr_wr_arb_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);

  arb_state_t          state;
  logic [PW:0]         cnt, cnt_nxt;
  logic                full, empty;
  logic [PW-1:0]       rptr;
  csr_wr_t             head, ex_ent, cl_ent, sel;
  csr_wr_t [DEPTH-1:0] ents;

  logic                stall, rd_hazard, ex_acc, push, pop, direct, issue;
  logic                buf_hit, out_hit;
  logic [CSR_DW-1:0]   buf_data;
  logic [PW-1:0]       idx;

  logic                we_q;
  csr_wr_t             out_q;

  assign ex_ent = '{addr: bus.ex_csr_waddr_i, data: bus.ex_csr_wdata_i};
  assign cl_ent = '{addr: bus.cl_csr_waddr_i, data: bus.cl_csr_wdata_i};

  csr_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_ent (ex_ent),
    .pop      (pop),
    .head     (head),
    .count    (cnt),
    .full     (full),
    .empty    (empty),
    .rptr     (rptr),
    .ents     (ents)
  );

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    buf_hit  = 1'b0;
    buf_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (((PW+1)'(i) < cnt) && (ents[idx].addr == bus.id_csr_raddr_i)) begin
        buf_hit  = 1'b1;
        buf_data = ents[idx].data;
      end
    end
  end

  assign out_hit = we_q & (out_q.addr == bus.id_csr_raddr_i);

`ifdef CSR_ARB_FWD_EN
  assign rd_hazard          = 1'b0;
  assign bus.id_csr_rdata_o = buf_hit ? buf_data :
                              out_hit ? out_q.data : bus.csr_rdata_i;
`else
  logic unused_fwd;
  assign unused_fwd         = ^buf_data;
  assign rd_hazard          = buf_hit | out_hit;
  assign bus.id_csr_rdata_o = bus.csr_rdata_i;
`endif

  // While the sequencer is busy, EX writes are held back so only the
  // existing buffer drains ahead of the trap writes.
  assign stall  = full | (bus.cl_busy_i & bus.ex_csr_we_i) | rd_hazard;
  assign ex_acc = bus.ex_csr_we_i & ~stall;
  assign pop    = ~bus.cl_csr_we_i & ~empty;
  assign push   = ex_acc & (bus.cl_csr_we_i | ~empty);
  assign direct = ex_acc & ~bus.cl_csr_we_i & empty;
  assign issue  = bus.cl_csr_we_i | ~empty | direct;

  always_comb begin
    sel = '0;
    if (bus.cl_csr_we_i) sel = cl_ent;
    else if (!empty)     sel = head;
    else if (direct)     sel = ex_ent;
  end

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + 1'b1;
    else if (pop && !push) cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      we_q  <= 1'b0;
      out_q <= '0;
    end else begin
      we_q <= issue;
      if (issue) out_q <= sel;
      if (bus.cl_busy_i)     state <= S_LOCK;
      else if (cnt_nxt == '0) state <= S_IDLE;
      else                   state <= S_BUF;
    end
  end

  assign bus.csr_we_o    = we_q;
  assign bus.csr_waddr_o = out_q.addr;
  assign bus.csr_wdata_o = out_q.data;
  assign bus.arb_stall_o = stall;
endmodule

// File: tb/tb_csr_wr_arb.sv
// tb_csr_wr_arb: directed self-checking bench for csr_wr_arb (DEPTH=2).
// Expectations follow the CSR_ARB_FWD_EN build option where they differ.
module tb_csr_wr_arb;
  import csr_wr_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   proto_cnt = 0;

  localparam logic [31:0] RAW = 32'hDEAD_BEEF;

  csr_wr_arb_if bus();

  csr_wr_arb #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // protocol monitor: a cl write while the buffer holds entries
  always @(negedge clk)
    if (!rst && bus.cl_csr_we_i && dut.cnt != 0) proto_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cl(input logic we, input logic [11:0] a, input logic [31:0] d);
    bus.cl_csr_we_i = we; bus.cl_csr_waddr_i = a; bus.cl_csr_wdata_i = d;
  endtask

  task automatic ex(input logic we, input logic [11:0] a, input logic [31:0] d);
    bus.ex_csr_we_i = we; bus.ex_csr_waddr_i = a; bus.ex_csr_wdata_i = d;
  endtask

  task automatic issued(input string tag, input logic [11:0] a, input logic [31:0] d);
    chk({tag, "_we"},   32'(bus.csr_we_o), 32'd1);
    chk({tag, "_addr"}, 32'(bus.csr_waddr_o), 32'(a));
    chk({tag, "_data"}, bus.csr_wdata_o, d);
  endtask

  task automatic st(input string tag, input logic [31:0] cnt_e, input arb_state_t s_e);
    chk({tag, "_cnt"},   32'(dut.cnt), cnt_e);
    chk({tag, "_state"}, 32'(dut.state), 32'(s_e));
  endtask

  initial begin
    rst = 1'b1;
    cl(0, '0, '0); ex(0, '0, '0);
    bus.cl_busy_i = 1'b0; bus.id_csr_raddr_i = '0; bus.csr_rdata_i = RAW;
    tick(); tick();
    chk("rst_we",    32'(bus.csr_we_o), 32'd0);
    chk("rst_waddr", 32'(bus.csr_waddr_o), 32'd0);
    chk("rst_wdata", bus.csr_wdata_o, 32'd0);
    chk("rst_stall", 32'(bus.arb_stall_o), 32'd0);
    st("rst", 0, S_IDLE);
    rst = 1'b0;

    // idle EX write goes straight out
    ex(1, 12'h341, 32'h80); #1;
    chk("idle_stall", 32'(bus.arb_stall_o), 32'd0);
    tick(); ex(0, '0, '0);
    issued("idle", 12'h341, 32'h80);
    st("idle", 0, S_IDLE);
    tick();
    chk("idle_quiet", 32'(bus.csr_we_o), 32'd0);

    // same-cycle cl and ex: cl first, ex buffered one cycle
    cl(1, CSR_MEPC, 32'h100); ex(1, 12'h340, 32'h5);
    tick(); cl(0, '0, '0); ex(0, '0, '0);
    issued("same_cl", CSR_MEPC, 32'h100);
    st("same_cl", 1, S_BUF);
    tick();
    issued("same_ex", 12'h340, 32'h5);
    st("same_ex", 0, S_IDLE);
    tick();
    chk("same_quiet", 32'(bus.csr_we_o), 32'd0);

    // three cl writes back to back while ex keeps offering writes
    cl(1, 12'h301, 32'h1); ex(1, 12'h310, 32'h11); #1;
    chk("fill1_stall", 32'(bus.arb_stall_o), 32'd0);
    tick(); issued("fill_a1", 12'h301, 32'h1); st("fill_a1", 1, S_BUF);
    cl(1, 12'h302, 32'h2); ex(1, 12'h311, 32'h12); #1;
    chk("fill2_stall", 32'(bus.arb_stall_o), 32'd0);
    tick(); issued("fill_a2", 12'h302, 32'h2); st("fill_a2", 2, S_BUF);
    cl(1, 12'h303, 32'h3); ex(1, 12'h312, 32'h13); #1;
    chk("full_stall", 32'(bus.arb_stall_o), 32'd1);
    tick(); issued("fill_a3", 12'h303, 32'h3); st("fill_a3", 2, S_BUF);
    cl(0, '0, '0); #1;
    chk("full_pop_stall", 32'(bus.arb_stall_o), 32'd1);
    tick(); issued("drain_e1", 12'h310, 32'h11); chk("drain_e1_cnt", 32'(dut.cnt), 32'd1);
    #1;
    chk("held_stall", 32'(bus.arb_stall_o), 32'd0);
    tick(); ex(0, '0, '0);
    issued("drain_e2", 12'h311, 32'h12); chk("drain_e2_cnt", 32'(dut.cnt), 32'd1);
    tick(); issued("drain_e3", 12'h312, 32'h13); st("drain_e3", 0, S_IDLE);
    chk("proto_flags", 32'(proto_cnt), 32'd2);
    tick();

    // read of a buffered address
    cl(1, CSR_MCAUSE, 32'h7); ex(1, CSR_MSTATUS, 32'hA);
    tick(); cl(0, '0, '0); ex(0, '0, '0);
    chk("fwd_cnt", 32'(dut.cnt), 32'd1);
    bus.id_csr_raddr_i = CSR_MCAUSE; #1;
`ifdef CSR_ARB_FWD_EN
    chk("fwd_out_rd",    bus.id_csr_rdata_o, 32'h7);
    chk("fwd_out_stall", 32'(bus.arb_stall_o), 32'd0);
`else
    chk("fwd_out_rd",    bus.id_csr_rdata_o, RAW);
    chk("fwd_out_stall", 32'(bus.arb_stall_o), 32'd1);
`endif
    bus.id_csr_raddr_i = CSR_MSTATUS; #1;
`ifdef CSR_ARB_FWD_EN
    chk("fwd_buf_rd",    bus.id_csr_rdata_o, 32'hA);
    chk("fwd_buf_stall", 32'(bus.arb_stall_o), 32'd0);
`else
    chk("fwd_buf_rd",    bus.id_csr_rdata_o, RAW);
    chk("fwd_buf_stall", 32'(bus.arb_stall_o), 32'd1);
`endif
    tick();
    issued("fwd_issue", CSR_MSTATUS, 32'hA);
`ifdef CSR_ARB_FWD_EN
    chk("fwd_reg_rd", bus.id_csr_rdata_o, 32'hA);
`else
    chk("fwd_reg_stall", 32'(bus.arb_stall_o), 32'd1);
`endif
    tick();
    chk("fwd_done_stall", 32'(bus.arb_stall_o), 32'd0);
    chk("fwd_done_rd", bus.id_csr_rdata_o, RAW);
    bus.id_csr_raddr_i = '0;

    // sequencer goes busy with two buffered entries
    cl(1, 12'h305, 32'h50); ex(1, 12'h306, 32'h61); tick();
    cl(1, 12'h305, 32'h51); ex(1, 12'h306, 32'h62); tick();
    chk("lock_pre_cnt", 32'(dut.cnt), 32'd2);
    cl(0, '0, '0); bus.cl_busy_i = 1'b1; ex(1, 12'h307, 32'h70);
    bus.id_csr_raddr_i = 12'h306; #1;
    chk("lock_stall", 32'(bus.arb_stall_o), 32'd1);
`ifdef CSR_ARB_FWD_EN
    chk("young_rd", bus.id_csr_rdata_o, 32'h62);
`else
    chk("young_rd", bus.id_csr_rdata_o, RAW);
`endif
    tick(); issued("lock_b1", 12'h306, 32'h61); st("lock_b1", 1, S_LOCK);
    tick(); issued("lock_b2", 12'h306, 32'h62); st("lock_b2", 0, S_LOCK);
    cl(1, CSR_MCAUSE, 32'h99); bus.id_csr_raddr_i = '0; #1;
    chk("lock_cl_stall", 32'(bus.arb_stall_o), 32'd1);
    tick(); cl(0, '0, '0); bus.cl_busy_i = 1'b0;
    issued("lock_cl", CSR_MCAUSE, 32'h99); st("lock_cl", 0, S_LOCK);
    #1;
    chk("unlock_stall", 32'(bus.arb_stall_o), 32'd0);
    tick(); ex(0, '0, '0);
    issued("unlock_ex", 12'h307, 32'h70); st("unlock_ex", 0, S_IDLE);
    tick();

    // reset mid-drain
    cl(1, CSR_MEPC, 32'hA0); ex(1, 12'h320, 32'h21); tick();
    cl(1, CSR_MEPC, 32'hA1); ex(1, 12'h321, 32'h22); tick();
    cl(0, '0, '0); ex(0, '0, '0);
    tick(); issued("pre_rst", 12'h320, 32'h21); chk("pre_rst_cnt", 32'(dut.cnt), 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("mid_rst_we", 32'(bus.csr_we_o), 32'd0);
    chk("mid_rst_addr", 32'(bus.csr_waddr_o), 32'd0);
    st("mid_rst", 0, S_IDLE);
    tick();
    chk("post_rst_we", 32'(bus.csr_we_o), 32'd0);
    st("post_rst", 0, S_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_wr_arb.md
CSR_WR_ARB -- requirements
Module: csr_wr_arb

Interface
REQ-001 Parameter: DEPTH, 2, pending EX CSR-write buffer entries (power of 2, >=2).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cl_csr_we_i / cl_csr_waddr_i / cl_csr_wdata_i  in  1/12/32  trap-sequencer CSR write.
REQ-005 cl_busy_i  in  1  trap sequencer busy (its stall output).
REQ-006 ex_csr_we_i / ex_csr_waddr_i / ex_csr_wdata_i  in  1/12/32  CSR-instruction write from EX.
REQ-007 id_csr_raddr_i  in  12  CSR address read by ID.
REQ-008 csr_rdata_i  in  32  raw read data from csr_regs for id_csr_raddr_i.
REQ-009 csr_we_o / csr_waddr_o / csr_wdata_o  out  1/12/32  registered write port to csr_regs.
REQ-010 id_csr_rdata_o  out  32  read data to ID, including pending writes.
REQ-011 arb_stall_o  out  1  combinational stall request to fc.

Function
REQ-012 Write port is shared; exactly one write, or none, is issued per cycle; output latency is 1 cycle from selection.
REQ-013 Selection priority per cycle: cl_csr_we_i, then buffer head, then ex_csr_we_i direct (buffer empty only).
REQ-014 ex write is enqueued when ex_csr_we_i=1, arb_stall_o=0, and (cl_csr_we_i=1 or buffer non-empty).
REQ-015 Simultaneous push and pop: count unchanged, head entry issued, new entry written at tail.
REQ-016 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-017 arb_stall_o=1 when count==DEPTH, or when cl_busy_i=1 and ex_csr_we_i=1; ex write is not accepted that cycle and is held by EX.
REQ-018 A slot freed by a pop is not usable by a push in the same cycle when count==DEPTH.
REQ-019 FSM S_IDLE (count 0, cl_busy_i 0), S_BUF (count>0, cl_busy_i 0), S_LOCK (cl_busy_i 1).
REQ-020 Transitions: IDLE->BUF on enqueue; BUF->IDLE on last pop without push; any->LOCK on cl_busy_i=1; LOCK->IDLE/BUF on cl_busy_i=0 by count.
REQ-021 In S_LOCK the buffer drains in priority order behind cl writes; no new ex entries enter.
REQ-022 A cl write issued while the buffer is non-empty is a protocol error and is flagged by a bench assertion.
REQ-023 id_csr_rdata_o forwarding order, newest first: youngest matching buffer entry, then matching csr_we_o output register, then csr_rdata_i.

Reset
REQ-024 rst=1 clears pointers and count, sets state S_IDLE, and drives csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0.
REQ-025 Buffer data is not cleared on reset; entries are invalidated by count=0.
REQ-026 Reset mid-drain discards all pending entries; no write issues in the cycle after reset.

Configuration
REQ-027 Macro CSR_ARB_FWD_EN defined: read forwarding per REQ-023.
REQ-028 CSR_ARB_FWD_EN undefined: id_csr_rdata_o=csr_rdata_i, and arb_stall_o is also asserted when id_csr_raddr_i matches any valid buffer entry or a pending csr_we_o.

Structure
REQ-029 The following constants belong in define.v: CSR address width 12, MSTATUS/MEPC/MCAUSE addresses, and FSM state encodings.
REQ-030 Sub-module csr_wr_fifo (DEPTH-entry {addr,data} FIFO with count, full, empty) is used; arbitration, FSM, and forwarding stay in csr_wr_arb.

Verification
REQ-031 Idle ex write 0x341/0x80 -> next cycle csr_we_o=1, waddr 0x341, wdata 0x80; count stays 0.
REQ-032 Same-cycle cl write MEPC=0x100 and ex write 0x340=0x5 -> MEPC issued at T+1, 0x340 issued at T+2.
REQ-033 Cl writes on 3 consecutive cycles while ex presents writes -> buffer reaches DEPTH=2, arb_stall_o=1, third ex write is held, no write is lost, and issue order is preserved.
REQ-034 Forwarding: buffered 0x300=0xA, then read 0x300 -> id_csr_rdata_o=0xA (macro on); macro off -> arb_stall_o=1 until the entry issues.
REQ-035 cl_busy_i rises with 2 buffered entries -> both entries issue before the first cl write, and no ex enqueue occurs while in S_LOCK.
REQ-036 rst asserted with 2 pending entries -> csr_we_o=0 at the next cycle, count=0, state S_IDLE.
